uart_baud_gen_frac: RTL

Parametrised UART baud-rate generator with a fractional divider and an oversampling tick chain. It produces an oversample tick (`OsTick`) for the receiver's sampling logic and a bit tick (`BitTick`) for the transmitter. Divisor changes are glitch-free, and a receiver resync input realigns the phase on a start-bit edge. It sits between the CPU-visible UART config registers and the UART TX/RX engines, replacing the fixed integer tick divider.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_frac_accum.sv | 42 ++++
 rtl/uart_baud_gen_frac.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default widths, oversampling ratio and per-baud
// divisor settings for a 50 MHz reference with x16 oversampling.
package uart_pkg;

    localparam int unsigned UART_DIV_W  = 16;
    localparam int unsigned UART_FRAC_W = 4;
    localparam int unsigned UART_OS     = 16;

    // N + F/16 clocks per oversample tick at 50 MHz, x16
    localparam int unsigned UART_DIV_9600    = 325;
    localparam int unsigned UART_FRAC_9600   = 8;
    localparam int unsigned UART_DIV_19200   = 162;
    localparam int unsigned UART_FRAC_19200  = 12;
    localparam int unsigned UART_DIV_57600   = 54;
    localparam int unsigned UART_FRAC_57600  = 4;
    localparam int unsigned UART_DIV_115200  = 27;
    localparam int unsigned UART_FRAC_115200 = 2;

    typedef struct packed {
        logic [UART_DIV_W-1:0]  div;
        logic [UART_FRAC_W-1:0] frac;
    } uart_div_cfg_t;

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: adds Frac on each Step and registers the
// carry out, which stretches the following period by one clock.
module uart_frac_accum
    import uart_pkg::*;
#(
    parameter int unsigned FRAC_W = UART_FRAC_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Step,
    input  logic              Clear,
    input  logic [FRAC_W-1:0] Frac,
    output logic              Carry
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (Clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (Step) begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, Frac};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign Carry = carry_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// UART baud generator: fractional N + F/2^FRAC_W divider producing oversample
// and bit ticks, with shadowed divisor updates and RX phase resync.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = UART_DIV_W,
    parameter int unsigned FRAC_W     = UART_FRAC_W,
    parameter int unsigned OVERSAMPLE = UART_OS,
    parameter int unsigned DEF_DIV    = UART_DIV_115200,
    parameter int unsigned DEF_FRAC   = UART_FRAC_115200
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Enable,
    input  logic [DIV_W-1:0]              Divisor,
    input  logic [FRAC_W-1:0]             Frac,
    input  logic                          LoadDiv,
    input  logic                          Resync,
    output logic                          OsTick,
    output logic                          BitTick,
    output logic [$clog2(OVERSAMPLE)-1:0] OsIdx,
    output logic                          CfgErr
);

    localparam int unsigned    OS_W    = $clog2(OVERSAMPLE);
    localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);

    logic [DIV_W-1:0]  div_act_q, div_act_d, div_pend_q, div_pend_d;
    logic [FRAC_W-1:0] frac_act_q, frac_act_d, frac_pend_q, frac_pend_d;
    logic              pend_v_q, pend_v_d;
    logic [DIV_W:0]    cnt_q, cnt_d;
    logic [OS_W-1:0]   os_idx_q, os_idx_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic              ext;
    logic [DIV_W:0]    period_m1;
    logic              period_end;
    logic              src_v;
    logic [DIV_W-1:0]  div_src;
    logic [FRAC_W-1:0] frac_src;
    logic              load_act;
    logic              accum_clr;

    // A LoadDiv in this cycle feeds the copy decision directly, so it lands
    // on this edge when the copy is immediate (idle, halted or resync).
    always_comb begin
        period_m1  = {1'b0, div_act_q} + {{DIV_W{1'b0}}, ext} - CNT_ONE;
        period_end = Enable && !cfg_err_q && (cnt_q >= period_m1);
        src_v      = LoadDiv || pend_v_q;
        div_src    = LoadDiv ? Divisor : div_pend_q;
        frac_src   = LoadDiv ? Frac : frac_pend_q;
        load_act   = src_v && (period_end || !Enable || cfg_err_q || Resync);
        accum_clr  = Resync || load_act || cfg_err_q;
    end

    always_comb begin
        div_pend_d  = div_pend_q;
        frac_pend_d = frac_pend_q;
        pend_v_d    = pend_v_q;
        div_act_d   = div_act_q;
        frac_act_d  = frac_act_q;
        if (LoadDiv) begin
            div_pend_d  = Divisor;
            frac_pend_d = Frac;
            pend_v_d    = 1'b1;
        end
        if (load_act) begin
            div_act_d  = div_src;
            frac_act_d = frac_src;
            pend_v_d   = 1'b0;
        end
        cfg_err_d = (div_act_d == '0);

        cnt_d = cnt_q;
        if (Resync || load_act || cfg_err_q || period_end) begin
            cnt_d = '0;
        end else if (Enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        os_idx_d = os_idx_q;
        if (Resync) begin
            os_idx_d = '0;
        end else if (period_end) begin
            os_idx_d = os_idx_q + OS_W'(1);
        end
        if (cfg_err_d) begin
            os_idx_d = '0;
        end

        os_tick_d  = period_end;
        bit_tick_d = period_end && (os_idx_d == '1);
    end

    uart_frac_accum #(
        .FRAC_W(FRAC_W)
    ) u_accum (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Step  (period_end),
        .Clear (accum_clr),
        .Frac  (frac_act_q),
        .Carry (ext)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_act_q   <= DIV_W'(DEF_DIV);
            frac_act_q  <= FRAC_W'(DEF_FRAC);
            div_pend_q  <= DIV_W'(DEF_DIV);
            frac_pend_q <= FRAC_W'(DEF_FRAC);
            pend_v_q    <= 1'b0;
            cnt_q       <= '0;
            os_idx_q    <= '0;
            os_tick_q   <= 1'b0;
            bit_tick_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            div_act_q   <= div_act_d;
            frac_act_q  <= frac_act_d;
            div_pend_q  <= div_pend_d;
            frac_pend_q <= frac_pend_d;
            pend_v_q    <= pend_v_d;
            cnt_q       <= cnt_d;
            os_idx_q    <= os_idx_d;
            os_tick_q   <= os_tick_d;
            bit_tick_q  <= bit_tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign OsTick  = os_tick_q;
    assign BitTick = bit_tick_q;
    assign OsIdx   = os_idx_q;
    assign CfgErr  = cfg_err_q;

endmodule
